// File: rtl/clk_div_bank_if.sv
// Control and output bundle for clk_div_bank.
// CLK_DIV_BANK_SYNC_CLR_EN adds the sync_clr phase-alignment input.
interface clk_div_bank_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 23,
    parameter int CH_W  = 4
);
    logic             en;
    logic             ld;
    logic [CH_W-1:0]  ld_ch;
    logic [CNT_W-1:0] ld_val;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;
`ifdef CLK_DIV_BANK_SYNC_CLR_EN
    logic             sync_clr;

    modport master (output en, ld, ld_ch, ld_val, sync_clr, input clk_out, tick);
    modport slave  (input en, ld, ld_ch, ld_val, sync_clr, output clk_out, tick);
`else
    modport master (output en, ld, ld_ch, ld_val, input clk_out, tick);
    modport slave  (input en, ld, ld_ch, ld_val, output clk_out, tick);
`endif
endinterface

// File: rtl/clk_div_bank.sv
// Bank of N_CH programmable 50%-duty clock dividers with per-channel tick strobes.
// Optional macro CLK_DIV_BANK_SYNC_CLR_EN adds a synchronous counter clear (sync_clr).
module clk_div_bank #(
    parameter int N_CH         = 2,
    parameter int CNT_W        = 23,
    parameter int DEFAULT_HALF = 5000000,
    parameter int CH_W         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    clk_div_bank_if.slave bus
);
    // Handshake: none. ld is a single-cycle strobe sampled on every rising edge;
    // ld_ch/ld_val are qualified by ld. Outputs are registered and always valid.

    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] r_cnt  [N_CH];
    logic [CNT_W-1:0] r_act  [N_CH];
    logic [CNT_W-1:0] r_pend [N_CH];
    logic [N_CH-1:0]  r_clk_out;
    logic [N_CH-1:0]  r_tick;

    logic [N_CH-1:0]  w_ld_hit;
    logic [N_CH-1:0]  w_term;
    logic [CNT_W-1:0] w_ld_val;
    logic             w_sync_clr;

`ifdef CLK_DIV_BANK_SYNC_CLR_EN
    assign w_sync_clr = bus.sync_clr;
`else
    assign w_sync_clr = 1'b0;
`endif

    // A zero half-period is meaningless, so it is stored as 1.
    always_comb begin
        w_ld_hit = '0;
        w_term   = '0;
        w_ld_val = (bus.ld_val == '0) ? CNT_W'(1) : bus.ld_val;
        for (int i = 0; i < N_CH; i++) begin
            w_ld_hit[i] = bus.ld && (bus.ld_ch == CH_W'(i));
            w_term[i]   = (r_cnt[i] == (r_act[i] - CNT_W'(1)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i]  <= '0;
                r_act[i]  <= DEF_H;
                r_pend[i] <= DEF_H;
            end
            r_clk_out <= '0;
            r_tick    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_ld_hit[i]) begin
                    r_pend[i] <= w_ld_val;
                end
                if (w_sync_clr) begin
                    r_cnt[i]     <= '0;
                    r_clk_out[i] <= 1'b0;
                    r_tick[i]    <= 1'b0;
                end else if (bus.en) begin
                    if (w_term[i]) begin
                        // act only changes here, so each phase runs a whole half-period
                        r_cnt[i]     <= '0;
                        r_clk_out[i] <= ~r_clk_out[i];
                        r_tick[i]    <= 1'b1;
                        r_act[i]     <= w_ld_hit[i] ? w_ld_val : r_pend[i];
                    end else begin
                        r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
                        r_tick[i] <= 1'b0;
                    end
                end else begin
                    r_tick[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.clk_out = r_clk_out;
    assign bus.tick    = r_tick;
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of N_CH independent frequency dividers sharing one input clock, each generating a 50 %-duty divided clock and a one-cycle tick strobe. It succeeds the fixed single-output divider used for slow display and debounce clocks. Each channel's half-period is runtime-programmable through a load port, and new values take effect glitch-free at the channel's next terminal count. Sits between the board clock and the scan, blink and debounce logic.

## Interface
- N_CH, 2: number of divider channels (1..16)
- CNT_W, 23: counter and half-period width in bits
- DEFAULT_HALF, 5000000: half-period (in clk cycles) loaded into every channel at reset; must be in 1..2^CNT_W-1
- CH_W, 4: width of the channel-select field (must satisfy 2^CH_W >= N_CH)

- clk  input  1  system clock, all logic on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  global count enable
- ld  input  1  load strobe for a half-period value
- ld_ch  input  CH_W  channel index for the load
- ld_val  input  CNT_W  new half-period value H
- clk_out  output  N_CH  divided clocks, one per channel, registered
- tick  output  N_CH  one-cycle strobe per channel at each toggle, registered

## Operation
- Per channel: counter cnt, active half-period act, pending half-period pend.
- Reset (rst_n low, asynchronous): cnt=0, clk_out=0, tick=0, act=pend=DEFAULT_HALF.
- Counting (en=1): if cnt==act-1, then cnt<=0, clk_out toggles, tick<=1, and act<=pend. Otherwise cnt<=cnt+1 and tick<=0.
- en=0: cnt, clk_out, act held; tick<=0. Loads are still accepted into pend.
- Load: when ld=1 and ld_ch<N_CH, pend[ld_ch]<=ld_val. When ld_ch>=N_CH, the load is ignored with no state change.
- ld_val==0 is stored as 1. H=1 means the channel toggles every enabled cycle and tick stays high continuously.
- A load in the same cycle as that channel's terminal count is applied immediately: act<=ld_val (clamped), bypassing pend.
- act never changes mid-half-period, so every clk_out high or low phase is exactly act cycles.
- Width rule: cnt compare and increment are CNT_W bits. cnt never exceeds act-1, so no wrap-around is possible.
- Channels are fully independent. Loading one channel never disturbs another channel's cnt or phase.

## Timing
- Output toggle period: clk_out period = 2·H enabled cycles; tick period = H enabled cycles.
- First event after reset release, with en held high: tick=1 and clk_out rises after exactly DEFAULT_HALF rising edges.
- Load latency: the new H governs the half-period that starts after the channel's next terminal count. The half-period currently in progress completes with the old H.
- en has one-cycle effect: counting freezes on the first edge where en=0 is sampled.
- Reset mid-operation: all outputs drop to 0 immediately, asynchronously. Pending loads are discarded and DEFAULT_HALF is restored.

## Configuration
- CLK_DIV_BANK_SYNC_CLR_EN defined:
  - Adds input port sync_clr (1 bit).
  - When sync_clr=1 on a rising edge: all cnt<=0, clk_out<=0, tick<=0; act and pend unchanged.
  - sync_clr has priority over terminal count and over en.
  - Used to phase-align all channels.
- Not defined: no sync_clr port and no such behaviour; only rst_n clears the counters.

## Test plan
- Reset/default: N_CH=2, DEFAULT_HALF=4, en=1 -> both tick=1 on edges 4, 8, 12; clk_out[0] rises at edge 4, falls at edge 8; period 8 cycles.
- Runtime load: load ch1 with H=2 at edge 2 -> ch1 keeps H=4 until edge 4, then ticks at 6, 8, 10; ch0 unaffected with ticks at 4, 8, 12.
- Boundary values:
  - ld_val=0 -> behaves as H=1: clk_out toggles every cycle, tick constant 1.
  - ld_ch=3 with N_CH=2 -> no channel changes.
- Simultaneous events: load ch0 with H=6 on the same edge as its terminal count -> next tick on ch0 comes 6 cycles later.
- Enable and reset:
  - en low for 5 cycles mid-count -> tick delayed by exactly 5 cycles, clk_out frozen.
  - rst_n pulsed low mid-period -> clk_out=0 immediately, H restored to 4.
- With CLK_DIV_BANK_SYNC_CLR_EN: pulse sync_clr at arbitrary phase -> both channels' next ticks coincide 4 cycles later.
